pixel_stream_reader: RTL and testbench

Reads a stored frame out of a synchronous-read pixel memory in raster order and drives it as a shift-enabled pixel stream (`pix_out` + `shift`) into the line-buffer shift registers of the streaming pixel pipeline. It is the producer end of the `shift`/`sr_in` interface. It absorbs the memory's one-cycle read latency and downstream stalls without dropping or duplicating pixels.

---
 rtl/pixel_stream_reader_pkg.sv | 28 ++
 rtl/pixel_stream_reader_if.sv | 32 +++
 rtl/pixel_stream_reader_skid_fifo.sv | 45 ++++
 rtl/pixel_stream_reader.sv | 138 +++++++++++++
 tb/tb_pixel_stream_reader.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_reader_pkg.sv
// Shared definitions for the pixel stream reader: FSM encoding, per-pixel tag
// layout and default frame geometry.
package pixel_stream_reader_pkg;

    localparam int DEF_NUM_BITS  = 8;
    localparam int DEF_WIDTH     = 320;
    localparam int DEF_HEIGHT    = 240;
    localparam int DEF_ADDR_BITS = 17;
    localparam int TAG_BITS      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    // Counter width for a 0..n-1 index; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_reader_if.sv
// Control, memory-read and pixel-stream signals of the pixel stream reader.
// Handshake: a pixel moves downstream exactly in cycles where shift=1; shift is
// out_valid && !stall, so stall acts as not-ready and may change every cycle.
interface pixel_stream_reader_if #(
    parameter int NUM_BITS  = 8,
    parameter int ADDR_BITS = 17
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic                 busy;
    logic                 done;
    logic                 mem_rd;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [NUM_BITS-1:0]  mem_rdata;
    logic [NUM_BITS-1:0]  pix_out;
    logic                 shift;
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic                 stall;

    modport master (
        input  start, base_addr, stall, mem_rdata,
        output busy, done, mem_rd, mem_addr, pix_out, shift, sof, eol, eof
    );

    modport slave (
        output start, base_addr, stall, mem_rdata,
        input  busy, done, mem_rd, mem_addr, pix_out, shift, sof, eol, eof
    );

endinterface

// File: rtl/pixel_stream_reader_skid_fifo.sv
// Two-entry FIFO used to absorb memory read latency against downstream stalls.
// Callers must never pop when empty nor push when full.
module skid_fifo #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);
    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q, count_d;

    always_comb begin
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && count_q == 2'd2));

endmodule

// File: rtl/pixel_stream_reader.sv
// Raster-order frame reader: issues throttled memory reads, realigns data with
// its position tags and presents one pixel per cycle on a stall-able stream.
module pixel_stream_reader
    import pixel_stream_reader_pkg::*;
#(
    parameter int NUM_BITS  = DEF_NUM_BITS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_stream_reader_if.master bus,
    output state_e               state_o
);
    localparam int COL_W = cnt_bits(WIDTH);
    localparam int ROW_W = cnt_bits(HEIGHT);
    localparam int FW    = NUM_BITS + TAG_BITS;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 inflight_q;
    tag_t                 rtag_q;
    logic [NUM_BITS-1:0]  pix_q;
    tag_t                 flags_q;
    logic                 out_valid_q;
    logic                 done_q;

    tag_t        issue_tag;
    logic        last_col, last_row;
    logic        rd, load, push, pop, shift;
    logic [2:0]  occ;
    logic [1:0]  count;
    logic [FW-1:0] head, in_word, load_word;

    assign last_col  = (col_q == COL_W'(WIDTH - 1));
    assign last_row  = (row_q == ROW_W'(HEIGHT - 1));
    assign issue_tag = '{sof: (row_q == '0) && (col_q == '0),
                         eol: last_col,
                         eof: last_col && last_row};

    // Returning data bypasses the empty FIFO straight into the output register,
    // which is what gives start-to-first-shift its three-cycle latency.
    assign shift     = out_valid_q && !bus.stall;
    assign load      = (!out_valid_q || shift) && ((count != 2'd0) || inflight_q);
    assign pop       = load && (count != 2'd0);
    assign push      = inflight_q && !(load && (count == 2'd0));
    assign in_word   = {bus.mem_rdata, rtag_q};
    assign load_word = (count != 2'd0) ? head : in_word;
    assign occ       = {1'b0, count} + {2'b00, inflight_q} - {2'b00, load};
    assign rd        = (state_q == ST_RUN) && (occ < 3'd2);

    skid_fifo #(.DW(FW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (in_word),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    addr_d  = bus.base_addr;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (rd) begin
                    addr_d = addr_q + 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (issue_tag.eof) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (shift && flags_q.eof) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            inflight_q  <= 1'b0;
            rtag_q      <= '0;
            pix_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= rd;
            if (rd) rtag_q <= issue_tag;
            if (load) begin
                {pix_q, flags_q} <= load_word;
                out_valid_q      <= 1'b1;
            end else if (shift) begin
                out_valid_q <= 1'b0;
            end
            done_q <= (state_q == ST_DRAIN) && shift && flags_q.eof;
        end
    end

    assign bus.mem_rd   = rd;
    assign bus.mem_addr = addr_q;
    assign bus.pix_out  = pix_q;
    assign bus.shift    = shift;
    assign bus.sof      = flags_q.sof;
    assign bus.eol      = flags_q.eol;
    assign bus.eof      = flags_q.eof;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed bench for pixel_stream_reader on a 4x3 frame with an 8-bit address
// space, so address wrap and every frame boundary are cheap to reach.
module tb_pixel_stream_reader;
    import pixel_stream_reader_pkg::*;

    localparam int NB = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AB = 8;
    localparam int N  = W * H;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_e state;
    int     n_checks = 0;
    int     n_errors = 0;
    logic [NB+2:0] exp_q[$];

    pixel_stream_reader_if #(.NUM_BITS(NB), .ADDR_BITS(AB)) bus ();

    pixel_stream_reader #(
        .NUM_BITS (NB),
        .WIDTH    (W),
        .HEIGHT   (H),
        .ADDR_BITS(AB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .state_o(state)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    // Synchronous-read memory: data[a] = a, valid only the cycle after a read.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rd ? bus.mem_addr[7:0] : 8'hEE;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return {21'd0, bus.eof, bus.eol, bus.sof, bus.pix_out};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"}, bus.mem_rd, 0);
        check({tag, "_shift"}, bus.shift, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pix_flags"}, out_word(), 0);
        check({tag, "_state"}, state, ST_IDLE);
    endtask

    // ---------------- frame driver + scoreboard ----------------
    // mode 0: no stall, 1: stall 5 cycles after 3rd shift, 2: random stall.
    task automatic run_frame(input logic [7:0] base, input int mode, input bit poke);
        int k, shifts, stall_left, stalled, first_k, done_k, eof_k, tail_rd, noisy;
        bit seen_done;
        logic [7:0] a;
        logic sof, eol, eof;
        k = 0; shifts = 0; stall_left = 0; stalled = 0; first_k = -1;
        done_k = -1; eof_k = -1; tail_rd = 0; noisy = 0; seen_done = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            a   = base + 8'(i);
            sof = (i == 0);
            eol = ((i % W) == W - 1);
            eof = eol && ((i / W) == H - 1);
            exp_q.push_back({eof, eol, sof, a});
        end

        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        while (!seen_done && k < 200) begin
            @(posedge clk); #1;
            k++;
            bus.start = poke && (k == 4);
            if (poke && k == 4) bus.base_addr = 8'h80;
            case (mode)
                1: begin
                    bus.stall = (stall_left > 0);
                    if (stall_left > 0) stall_left--;
                end
                2: bus.stall = 1'($urandom_range(0, 1));
                default: bus.stall = 1'b0;
            endcase
            @(negedge clk);
            if (k == 1) begin
                check("start_busy", bus.busy, 1);
                check("start_mem_rd", bus.mem_rd, 1);
                check("start_mem_addr", bus.mem_addr, base);
            end
            if (mode == 1 && bus.stall) begin
                stalled++;
                if (stalled > 1 && bus.mem_rd) tail_rd++;
                if (exp_q.size() != 0) check("stall_hold", out_word(), exp_q[0]);
            end
            if (bus.shift) begin
                shifts++;
                if (first_k < 0) first_k = k;
                if (exp_q.size() == 0) check("extra_shift", 1, 0);
                else check("pixel", out_word(), exp_q.pop_front());
                if (bus.eof) eof_k = k;
                if (mode == 1 && shifts == 3) stall_left = 5;
            end
            if (bus.done) begin
                seen_done = 1;
                done_k    = k;
                check("busy_at_done", bus.busy, 0);
            end
        end
        bus.stall = 1'b0;
        if (!seen_done) check("timeout", 0, 1);
        check("shift_count", shifts, N);
        check("sb_empty", exp_q.size(), 0);
        check("done_after_eof", done_k, eof_k + 1);
        if (mode != 2) begin
            check("first_shift_k", first_k, 3);
            check("done_k", done_k, 3 + N + ((mode == 1) ? 5 : 0));
        end
        if (mode == 1) check("rd_in_stall_tail", tail_rd, 0);
        repeat (4) begin
            @(negedge clk);
            if (bus.shift || bus.busy || bus.done) noisy++;
        end
        check("idle_quiet", noisy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt, guard;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.stall     = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_mem_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_frame(8'h10, 0, 1'b0);
        run_frame(8'h10, 1, 1'b0);
        run_frame(8'h20, 2, 1'b0);
        run_frame(8'h30, 2, 1'b0);
        run_frame(8'h10, 0, 1'b1);

        // Abort a frame after five transfers, then start a fresh one.
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = 8'h10;
        cnt = 0; guard = 0;
        while (cnt < 5 && guard < 50) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            guard++;
            @(negedge clk);
            if (bus.shift) begin
                check("pre_reset_pixel", bus.pix_out, 8'h10 + 8'(cnt));
                cnt++;
            end
        end
        check("pre_reset_shifts", cnt, 5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        run_frame(8'h40, 0, 1'b0);

        run_frame(8'hFE, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
